// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths and writeback request type
package regfile_pkg;
    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rtl/regfile_wb_arbiter_rr.sv - round-robin arbiter with one-hot grant and index
module rr_arbiter #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;
    logic          found;

    // Scan from the pointer and wrap, taking the first requester seen.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en && found) begin
            ptr <= (int'(idx) == N - 1) ? '0 : idx + IW'(1);
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port and tracks pending writes
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int  NREQ = 2,
    parameter int  DW   = REG_DW,
    parameter int  AW   = REG_AW,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_set_addr,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_a3,
    output logic [DW-1:0]        rf_wd3,
    output logic [NUM_REGS-1:0]  busy
);
    logic [NREQ-1:0]     req_gated;
    logic [NREQ-1:0]     grant;
    logic [IW-1:0]       gidx;
    logic                hs;
    wb_req_t             sel;
    logic [NUM_REGS-1:0] busy_nxt;

    // No ready may be seen while reset is held, even though valid may be up.
    assign req_gated = rst_n ? req_valid : '0;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_gated),
        .en    (1'b1),
        .grant (grant),
        .idx   (gidx)
    );

    assign req_ready = grant;
    assign hs        = |grant;

    always_comb begin
        sel      = '0;
        sel.addr = req_addr[int'(gidx)*AW +: AW];
        sel.data = req_data[int'(gidx)*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we  <= 1'b0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else if (hs) begin
            rf_we  <= (sel.addr != REG_ZERO);
            rf_a3  <= sel.addr;
            rf_wd3 <= sel.data;
        end else begin
            rf_we  <= 1'b0;
        end
    end

    // Clear before set so a fresh issue to the committing register stays pending.
    always_comb begin
        busy_nxt = busy;
        if (rf_we) begin
            busy_nxt[rf_a3] = 1'b0;
        end
        if (sb_set && (sb_set_addr != REG_ZERO)) begin
            busy_nxt[sb_set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_data = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_set_addr = '0;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [31:0] busy;

    int compared = 0;
    int mismatched = 0;

    regfile_wb_arbiter #(.NREQ(2), .DW(32), .AW(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd3      (rf_wd3),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // A source may not withdraw valid before it has been accepted.
    logic [1:0] pend_q = '0;
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (pend_q[i] && !req_valid[i]) begin
                    mismatched++;
                    $display("FAIL valid_drop src%0d got valid=0 want 1", i);
                end
            end
            pend_q = req_valid & ~req_ready;
        end else begin
            pend_q = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [4:0] a, input logic [31:0] d);
        req_addr[s*5 +: 5]  = a;
        req_data[s*32 +: 32] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        set_src(0, 5'd0, 32'h0);
        set_src(1, 5'd0, 32'h0);
        tick();
        tick();
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("FAIL reset_ready got %b want 00", req_ready); end
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL reset_we got %b want 0", rf_we); end
        compared++; if (busy !== 32'h0) begin mismatched++; $display("FAIL reset_busy got %h want 0", busy); end
        compared++; if (rf_a3 !== 5'd0 || rf_wd3 !== 32'h0) begin mismatched++; $display("FAIL reset_out got %0d/%h want 0/0", rf_a3, rf_wd3); end
        rst_n = 1'b1;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL reset_second_grant got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_single();
        set_src(1, 5'd7, 32'hDEADBEEF);
        req_valid = 2'b10;
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL single_ready got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        compared++; if (rf_we !== 1'b1) begin mismatched++; $display("FAIL single_we got %b want 1", rf_we); end
        compared++; if (rf_a3 !== 5'd7) begin mismatched++; $display("FAIL single_a3 got %0d want 7", rf_a3); end
        compared++; if (rf_wd3 !== 32'hDEADBEEF) begin mismatched++; $display("FAIL single_wd3 got %h want deadbeef", rf_wd3); end
        tick();
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL single_we_after got %b want 0", rf_we); end
        compared++; if (rf_a3 !== 5'd7) begin mismatched++; $display("FAIL single_a3_hold got %0d want 7", rf_a3); end
    endtask

    task automatic test_contention();
        logic [1:0] vtab [4] = '{2'b11, 2'b11, 2'b11, 2'b10};
        logic [4:0] a0tab[4] = '{5'd1, 5'd2, 5'd2, 5'd0};
        logic [4:0] a1tab[4] = '{5'd9, 5'd9, 5'd10, 5'd10};
        logic [1:0] rtab [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [4:0] otab [4] = '{5'd1, 5'd9, 5'd2, 5'd10};
        for (int k = 0; k < 4; k++) begin
            req_valid = vtab[k];
            set_src(0, a0tab[k], 32'h100 + 32'(a0tab[k]));
            set_src(1, a1tab[k], 32'h100 + 32'(a1tab[k]));
            #1;
            compared++; if (req_ready !== rtab[k]) begin mismatched++; $display("FAIL cont_ready%0d got %b want %b", k, req_ready, rtab[k]); end
            tick();
            compared++; if (rf_we !== 1'b1 || rf_a3 !== otab[k]) begin mismatched++; $display("FAIL cont_a3_%0d got we=%b a3=%0d want we=1 a3=%0d", k, rf_we, rf_a3, otab[k]); end
            compared++; if (rf_wd3 !== 32'h100 + 32'(otab[k])) begin mismatched++; $display("FAIL cont_wd3_%0d got %h want %h", k, rf_wd3, 32'h100 + 32'(otab[k])); end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_r0_drop();
        set_src(0, 5'd0, 32'h1);
        req_valid = 2'b01;
        sb_set = 1'b1;
        sb_set_addr = 5'd3;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL r0_ready got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        sb_set = 1'b0;
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL r0_we got %b want 0", rf_we); end
        compared++; if (rf_a3 !== 5'd0 || rf_wd3 !== 32'h1) begin mismatched++; $display("FAIL r0_out got %0d/%h want 0/1", rf_a3, rf_wd3); end
        compared++; if (busy !== 32'h8) begin mismatched++; $display("FAIL r0_busy got %h want 8", busy); end
        tick();
        compared++; if (busy !== 32'h8) begin mismatched++; $display("FAIL r0_busy_after got %h want 8", busy); end
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1;
        sb_set_addr = 5'd5;
        tick();
        compared++; if (busy !== 32'h28) begin mismatched++; $display("FAIL sb_set5 got %h want 28", busy); end
        sb_set_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        compared++; if (busy !== 32'h28) begin mismatched++; $display("FAIL sb_set0_ignored got %h want 28", busy); end
        set_src(0, 5'd5, 32'h55);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        compared++; if (rf_we !== 1'b1 || busy !== 32'h28) begin mismatched++; $display("FAIL sb_precommit got we=%b busy=%h want we=1 busy=28", rf_we, busy); end
        tick();
        compared++; if (busy !== 32'h08) begin mismatched++; $display("FAIL sb_commit_clear got %h want 08", busy); end
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        sb_set = 1'b1;
        sb_set_addr = 5'd5;
        tick();
        sb_set = 1'b0;
        compared++; if (busy !== 32'h28) begin mismatched++; $display("FAIL sb_set_wins got %h want 28", busy); end
        set_src(0, 5'd3, 32'h33);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        sb_set = 1'b1;
        sb_set_addr = 5'd6;
        tick();
        sb_set = 1'b0;
        compared++; if (busy !== 32'h60) begin mismatched++; $display("FAIL sb_set_clear_diff got %h want 60", busy); end
    endtask

    task automatic test_async_reset();
        set_src(1, 5'd12, 32'hC0FFEE);
        req_valid = 2'b10;
        #1;
        compared++; if (req_ready !== 2'b10) begin mismatched++; $display("FAIL ar_ready got %b want 10", req_ready); end
        tick();
        req_valid = 2'b00;
        compared++; if (rf_we !== 1'b1) begin mismatched++; $display("FAIL ar_inflight_we got %b want 1", rf_we); end
        #1;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        compared++; if (rf_we !== 1'b0) begin mismatched++; $display("FAIL ar_we got %b want 0", rf_we); end
        compared++; if (busy !== 32'h0) begin mismatched++; $display("FAIL ar_busy got %h want 0", busy); end
        compared++; if (req_ready !== 2'b00) begin mismatched++; $display("FAIL ar_ready_held got %b want 00", req_ready); end
        rst_n = 1'b1;
        #1;
        compared++; if (req_ready !== 2'b01) begin mismatched++; $display("FAIL ar_ptr got %b want 01", req_ready); end
        tick();
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_r0_drop();
        test_scoreboard();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
